mem_arbiter: RTL and testbench

//   Shares the single byte-wide RAM port between instruction fetch (IF) and the

---
 rtl/mem_arbiter_if.sv | 32 +++
 rtl/mem_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the RV32I pipeline ports, the byte-wide RAM and mem_arbiter.
// master = pipeline/RAM side (testbench), slave = the arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_W = 17
) ();
  logic              if_req;
  logic [31:0]       if_addr;
  logic [31:0]       if_data;
  logic              if_done;
  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_size;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_done;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wr;
  logic [7:0]        ram_dout;
  logic [7:0]        ram_din;
  logic              busy;

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_size, mem_addr, mem_wdata, ram_din,
    input  if_data, if_done, mem_rdata, mem_done, ram_addr, ram_wr, ram_dout, busy
  );

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_size, mem_addr, mem_wdata, ram_din,
    output if_data, if_done, mem_rdata, mem_done, ram_addr, ram_wr, ram_dout, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one byte-wide RAM port between IF and MEM: arbitrates, then moves 1/2/4
// bytes one per cycle (little-endian) and returns assembled words with done pulses.
module mem_arbiter #(
  parameter int ADDR_W = 17
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_WAIT, S_DONE} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_base;
  logic [1:0]        r_cnt;
  logic [1:0]        r_last;
  logic              r_we;
  logic              r_own_if;
  logic              r_lose_if;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rbuf;
  logic [ADDR_W-1:0] r_ram_addr;
  logic              r_ram_wr;
  logic [7:0]        r_ram_dout;
  logic [31:0]       r_if_data;
  logic [31:0]       r_mem_rdata;
  logic              r_if_done;
  logic              r_mem_done;
  logic              r_busy;

  logic              w_gnt_if;
  logic              w_gnt_mem;
  logic              w_st;
  logic [1:0]        w_size_last;
  logic [1:0]        w_cnt_nx;
  logic [1:0]        w_cnt_pv;
  logic [ADDR_W-1:0] w_addr_nx;
  logic [ADDR_W-1:0] w_req_addr;
  logic [31:0]       w_rword;

  // MEM has priority unless IF already lost once; that makes IF win the next round.
  assign w_gnt_if    = bus.if_req && (!bus.mem_req || r_lose_if);
  assign w_gnt_mem   = bus.mem_req && !w_gnt_if;
  assign w_st        = w_gnt_mem && bus.mem_we;
  assign w_size_last = bus.mem_size[1] ? 2'd3 : {1'b0, bus.mem_size[0]};
  assign w_req_addr  = w_gnt_if ? bus.if_addr[ADDR_W-1:0] : bus.mem_addr[ADDR_W-1:0];
  assign w_cnt_nx    = r_cnt + 2'd1;
  assign w_cnt_pv    = r_cnt - 2'd1;
  assign w_addr_nx   = r_base + ADDR_W'(w_cnt_nx);

  // Final read byte arrives while in WAIT; merge it straight into the result.
  always_comb begin
    w_rword = r_rbuf;
    w_rword[{r_cnt, 3'b000} +: 8] = bus.ram_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_lose_if   <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wr    <= 1'b0;
      r_ram_dout  <= 8'h00;
      r_if_data   <= 32'h0;
      r_mem_rdata <= 32'h0;
      r_if_done   <= 1'b0;
      r_mem_done  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt_if || w_gnt_mem) begin
            r_own_if   <= w_gnt_if;
            r_we       <= w_st;
            r_base     <= w_req_addr;
            r_last     <= w_gnt_if ? 2'd3 : w_size_last;
            r_wdata    <= bus.mem_wdata;
            r_cnt      <= 2'd0;
            r_rbuf     <= 32'h0;
            r_ram_addr <= w_req_addr;
            r_ram_wr   <= w_st;
            r_ram_dout <= w_st ? bus.mem_wdata[7:0] : 8'h00;
            r_busy     <= 1'b1;
            r_state    <= S_XFER;
            if (w_gnt_if)        r_lose_if <= 1'b0;
            else if (bus.if_req) r_lose_if <= 1'b1;
          end
        end
        S_XFER: begin
          // ram_din lags ram_addr by one cycle, so this captures byte r_cnt-1.
          if (r_cnt != 2'd0) r_rbuf[{w_cnt_pv, 3'b000} +: 8] <= bus.ram_din;
          if (r_cnt == r_last) begin
            r_ram_wr   <= 1'b0;
            r_ram_dout <= 8'h00;
            if (r_we) begin
              r_mem_done <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              r_state    <= S_WAIT;
            end
          end else begin
            r_cnt      <= w_cnt_nx;
            r_ram_addr <= w_addr_nx;
            r_ram_dout <= r_we ? r_wdata[{w_cnt_nx, 3'b000} +: 8] : 8'h00;
          end
        end
        S_WAIT: begin
          if (r_own_if) begin
            r_if_data  <= w_rword;
            r_if_done  <= 1'b1;
          end else begin
            r_mem_rdata <= w_rword;
            r_mem_done  <= 1'b1;
          end
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_if_done  <= 1'b0;
          r_mem_done <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ram_addr  = r_ram_addr;
  assign bus.ram_wr    = r_ram_wr;
  assign bus.ram_dout  = r_ram_dout;
  assign bus.if_data   = r_if_data;
  assign bus.mem_rdata = r_mem_rdata;
  assign bus.if_done   = r_if_done;
  assign bus.mem_done  = r_mem_done;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model expanded into a per-cycle
// expectation queue, directed cases with literal expectations, then random traffic.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int ADDR_W = 17;
  localparam int MEMSZ  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();
  mem_arbiter #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [7:0] ram    [MEMSZ];
  logic [7:0] shadow [MEMSZ];

  // Synchronous-read RAM: data for an address appears the following cycle.
  always @(posedge clk) bus.ram_din <= ram[bus.ram_addr];

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        dout;
    logic              wr;
    logic              chk_a;
    logic              chk_d;
    logic              ifd;
    logic              memd;
    logic              upd;
    logic [31:0]       data;
  } ent_t;

  ent_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic [31:0] x_if_data = 32'h0, x_mem_rdata = 32'h0;
  logic        lose = 1'b0, rstv = 1'b1, m_idle = 1'b1;
  logic        e_ifd = 1'b0, e_memd = 1'b0;
  logic        if_pend = 1'b0, mem_pend = 1'b0, if_gr = 1'b0, mem_gr = 1'b0;
  logic [31:0] ob_addr [16];
  logic        ob_wr   [16];
  logic [7:0]  ob_dout [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic poke(input int a, input logic [7:0] d);
    ram[a]    = d;
    shadow[a] = d;
  endtask

  // Expected behaviour of one cycle, checked on the falling edge.
  task automatic tick_check();
    ent_t e;
    @(negedge clk);
    cyc++;
    m_idle = (q.size() == 0);
    if (!m_idle) e = q.pop_front();
    else begin
      e.addr = '0; e.dout = 8'h00; e.wr = 1'b0; e.chk_a = rstv; e.chk_d = rstv;
      e.ifd = 1'b0; e.memd = 1'b0; e.upd = 1'b0; e.data = 32'h0;
    end
    if (e.ifd && e.upd)  x_if_data   = e.data;
    if (e.memd && e.upd) x_mem_rdata = e.data;
    if (e.wr) shadow[e.addr] = e.dout;
    e_ifd  = e.ifd;
    e_memd = e.memd;
    chk("busy",      32'(bus.busy),     32'(!m_idle));
    chk("ram_wr",    32'(bus.ram_wr),   32'(e.wr));
    chk("if_done",   32'(bus.if_done),  32'(e.ifd));
    chk("mem_done",  32'(bus.mem_done), 32'(e.memd));
    chk("if_data",   bus.if_data,       x_if_data);
    chk("mem_rdata", bus.mem_rdata,     x_mem_rdata);
    if (e.chk_a) chk("ram_addr", 32'(bus.ram_addr), 32'(e.addr));
    if (e.chk_d) chk("ram_dout", 32'(bus.ram_dout), 32'(e.dout));
    if (bus.ram_wr === 1'b1) ram[bus.ram_addr] = bus.ram_dout;
  endtask

  task automatic grant();
    logic gif, gmem, we;
    int n;
    logic [ADDR_W-1:0] base;
    logic [31:0] wd, word;
    ent_t e;
    gif  = bus.if_req && (!bus.mem_req || lose);
    gmem = bus.mem_req && !gif;
    if (!gif && !gmem) return;
    if (gif) lose = 1'b0;
    else if (bus.if_req) lose = 1'b1;
    if (gif) begin
      if_gr = 1'b1; we = 1'b0; n = 4; base = bus.if_addr[ADDR_W-1:0]; wd = 32'h0;
    end else begin
      mem_gr = 1'b1; we = bus.mem_we; base = bus.mem_addr[ADDR_W-1:0]; wd = bus.mem_wdata;
      n = (bus.mem_size == 2'd0) ? 1 : (bus.mem_size == 2'd1) ? 2 : 4;
    end
    word = 32'h0;
    for (int k = 0; k < n; k++) begin
      e.addr = base + ADDR_W'(k);
      e.wr = we; e.dout = we ? wd[8*k +: 8] : 8'h00;
      e.chk_a = 1'b1; e.chk_d = 1'b1; e.ifd = 1'b0; e.memd = 1'b0; e.upd = 1'b0; e.data = 32'h0;
      if (!we) word[8*k +: 8] = shadow[e.addr];
      q.push_back(e);
    end
    e.wr = 1'b0; e.dout = 8'h00; e.chk_d = 1'b0;
    if (!we) q.push_back(e);
    e.chk_a = 1'b0; e.ifd = gif; e.memd = gmem; e.upd = !we; e.data = word;
    q.push_back(e);
  endtask

  task automatic tick_model();
    if (rst) begin
      q.delete();
      x_if_data = 32'h0; x_mem_rdata = 32'h0;
      lose = 1'b0; rstv = 1'b1; if_gr = 1'b0; mem_gr = 1'b0;
    end else begin
      rstv = 1'b0;
      if (m_idle) grant();
    end
  endtask

  // One transaction from an idle cycle through its done cycle; operands are
  // scrambled after the grant to show they were latched.
  task automatic do_txn(input logic is_if, input logic we, input logic [1:0] sz,
                        input logic [31:0] addr, input logic [31:0] wd, output int lat);
    tick_check();
    if (is_if) begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end else begin
      bus.mem_req = 1'b1; bus.mem_we = we; bus.mem_size = sz;
      bus.mem_addr = addr; bus.mem_wdata = wd;
    end
    lat = -1;
    tick_model();
    for (int i = 1; i < 16; i++) begin
      tick_check();
      ob_addr[i] = 32'(bus.ram_addr); ob_wr[i] = bus.ram_wr; ob_dout[i] = bus.ram_dout;
      if ((is_if ? bus.if_done : bus.mem_done) === 1'b1 && lat < 0) lat = i;
      if (i == 1) begin
        bus.if_addr = ~addr; bus.mem_addr = ~addr; bus.mem_wdata = ~wd; bus.mem_size = ~sz;
      end
      if (e_ifd || e_memd) begin
        bus.if_req = 1'b0; bus.mem_req = 1'b0; if_gr = 1'b0; mem_gr = 1'b0;
        tick_model();
        break;
      end
      tick_model();
    end
  endtask

  initial begin
    int lat, d_m1, d_if, d_m2, seen2;
    logic saw;
    logic [7:0]  sw_b [4];
    logic [31:0] wr_a [4];
    sw_b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    wr_a = '{32'h1FFFF, 32'h0, 32'h1, 32'h2};
    for (int i = 0; i < MEMSZ; i++) begin
      ram[i] = 8'($urandom);
      shadow[i] = ram[i];
    end
    rst = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = 32'h0; bus.mem_req = 1'b0; bus.mem_we = 1'b0;
    bus.mem_size = 2'd0; bus.mem_addr = 32'h0; bus.mem_wdata = 32'h0;

    for (int i = 0; i < 3; i++) begin
      tick_check();
      rst = (i < 2);
      tick_model();
    end
    chk("reset_busy", 32'(bus.busy), 32'h0);
    chk("reset_addr", 32'(bus.ram_addr), 32'h0);

    // IF word fetch
    poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'h10); poke(32'h103, 8'h00);
    do_txn(1'b1, 1'b0, 2'd2, 32'h100, 32'h0, lat);
    chk("t1_lat", 32'(lat), 32'd6);
    chk("t1_data", bus.if_data, 32'h00100513);
    for (int k = 1; k <= 4; k++) chk("t1_addr", ob_addr[k], 32'h100 + 32'(k - 1));

    // MEM word store
    do_txn(1'b0, 1'b1, 2'd2, 32'h20, 32'hDEADBEEF, lat);
    chk("t2_lat", 32'(lat), 32'd5);
    for (int k = 1; k <= 4; k++) begin
      chk("t2_wr", 32'(ob_wr[k]), 32'h1);
      chk("t2_dout", 32'(ob_dout[k]), 32'(sw_b[k-1]));
    end
    chk("t2_wr_done", 32'(ob_wr[5]), 32'h0);
    chk("t2_ram", {ram[32'h23], ram[32'h22], ram[32'h21], ram[32'h20]}, 32'hDEADBEEF);

    // MEM byte load, IF data untouched
    poke(7, 8'h80);
    do_txn(1'b0, 1'b0, 2'd0, 32'h7, 32'h0, lat);
    chk("t4_lat", 32'(lat), 32'd3);
    chk("t4_rdata", bus.mem_rdata, 32'h00000080);
    chk("t4_if_data", bus.if_data, 32'h00100513);

    // Both request: MEM, then IF (despite MEM re-request), then MEM
    poke(32'h40, 8'h44); poke(32'h41, 8'h33); poke(32'h42, 8'h22); poke(32'h43, 8'h11);
    poke(32'h60, 8'h88); poke(32'h61, 8'h77); poke(32'h62, 8'h66); poke(32'h63, 8'h55);
    tick_check();
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_size = 2'd2; bus.mem_addr = 32'h40;
    tick_model();
    d_m1 = -1; d_if = -1; d_m2 = -1; seen2 = 0;
    for (int i = 1; i < 40 && seen2 < 2; i++) begin
      tick_check();
      if (bus.mem_done === 1'b1) begin
        if (d_m1 < 0) d_m1 = i; else d_m2 = i;
      end
      if (bus.if_done === 1'b1) d_if = i;
      if (e_memd) begin
        seen2++;
        if (seen2 == 1) bus.mem_addr = 32'h60;
        else bus.mem_req = 1'b0;
      end
      if (e_ifd) bus.if_req = 1'b0;
      tick_model();
    end
    chk("t3_mem1", 32'(d_m1), 32'd6);
    chk("t3_if", 32'(d_if), 32'd13);
    chk("t3_mem2", 32'(d_m2), 32'd20);
    chk("t3_if_data", bus.if_data, 32'h00100513);
    chk("t3_rdata", bus.mem_rdata, 32'h55667788);

    // Address wrap at 2^ADDR_W, upper address bits ignored
    poke(32'h1FFFF, 8'hAA); poke(0, 8'hBB); poke(1, 8'hCC); poke(2, 8'hDD);
    do_txn(1'b1, 1'b0, 2'd2, 32'h8001FFFF, 32'h0, lat);
    for (int k = 1; k <= 4; k++) chk("t6_addr", ob_addr[k], wr_a[k-1]);
    chk("t6_data", bus.if_data, 32'hDDCCBBAA);

    // Reset in cycle 2 of a word store
    poke(32'h80, 8'h00); poke(32'h81, 8'h00); poke(32'h82, 8'h00); poke(32'h83, 8'h00);
    tick_check();
    bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_size = 2'd2;
    bus.mem_addr = 32'h80; bus.mem_wdata = 32'hCAFEF00D;
    tick_model();
    tick_check(); tick_model();
    tick_check(); rst = 1'b1; bus.mem_req = 1'b0; tick_model();
    tick_check(); rst = 1'b0;
    chk("t5_wr", 32'(bus.ram_wr), 32'h0);
    chk("t5_busy", 32'(bus.busy), 32'h0);
    saw = bus.mem_done;
    tick_model();
    repeat (4) begin
      tick_check();
      if (bus.mem_done === 1'b1) saw = 1'b1;
      tick_model();
    end
    chk("t5_nodone", 32'(saw), 32'h0);
    do_txn(1'b1, 1'b0, 2'd2, 32'h80, 32'h0, lat);
    chk("t5_if_lat", 32'(lat), 32'd6);
    chk("t5_partial", bus.if_data, 32'h0000F00D);

    // Random traffic
    if_pend = 1'b0; mem_pend = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      tick_check();
      rst = 1'b0;
      if (e_ifd)  begin if_pend = 1'b0;  if_gr = 1'b0;  bus.if_req = 1'b0;  end
      if (e_memd) begin mem_pend = 1'b0; mem_gr = 1'b0; bus.mem_req = 1'b0; end
      if ($urandom_range(199) == 0) begin
        rst = 1'b1; bus.if_req = 1'b0; bus.mem_req = 1'b0; if_pend = 1'b0; mem_pend = 1'b0;
      end else begin
        if (!if_pend && $urandom_range(2) == 0) begin
          bus.if_req = 1'b1; if_pend = 1'b1;
          bus.if_addr = ($urandom_range(3) == 0) ? 32'h0001FFFE : $urandom;
        end else if (if_gr && $urandom_range(3) == 0) bus.if_addr = $urandom;
        if (!mem_pend && $urandom_range(2) == 0) begin
          bus.mem_req = 1'b1; mem_pend = 1'b1;
          bus.mem_we = 1'($urandom_range(1)); bus.mem_size = 2'($urandom_range(3));
          bus.mem_addr = ($urandom_range(3) == 0) ? 32'h0003FFFF : $urandom;
          bus.mem_wdata = $urandom;
        end else if (mem_gr && $urandom_range(3) == 0) begin
          bus.mem_addr = $urandom; bus.mem_wdata = $urandom;
          bus.mem_we = 1'($urandom_range(1)); bus.mem_size = 2'($urandom_range(3));
        end
      end
      tick_model();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
